// File: rtl/logic_unit_32.sv
// logic_unit_32: registered AND/NAND/NOR unit, 1-cycle latency, no backpressure (outputs hold while en=0).
// Optional registered zero flag is compiled in with LOGIC32_ZERO_FLAG_EN.
module logic_unit_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             illegal_op
`ifdef LOGIC32_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [WIDTH-1:0] result;

  // Reserved op resolves to all-zero so out and zero stay well defined.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      out_valid  <= 1'b0;
      illegal_op <= 1'b0;
    end else if (en) begin
      out        <= result;
      out_valid  <= 1'b1;
      illegal_op <= (op == OP_RSVD);
    end else begin
      out_valid  <= 1'b0;
      illegal_op <= 1'b0;
    end
  end

`ifdef LOGIC32_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
    end else if (en) begin
      zero <= ~|result;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_32.sv
// Self-checking bench for logic_unit_32: directed steps plus randomized traffic against a per-bit reference model.
module tb_logic_unit_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic        out_valid;
  logic        illegal_op;
`ifdef LOGIC32_ZERO_FLAG_EN
  logic        zero;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the outputs must show after the latest edge.
  logic [31:0] m_out  = 32'h0;
  logic        m_vld  = 1'b0;
  logic        m_ill  = 1'b0;
  logic        m_zero = 1'b0;

  logic [31:0] held;

  logic_unit_32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .op         (op),
    .a          (a),
    .b          (b),
    .out        (out),
    .out_valid  (out_valid),
    .illegal_op (illegal_op)
`ifdef LOGIC32_ZERO_FLAG_EN
    ,
    .zero       (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit evaluation straight from the function table.
  function automatic logic [31:0] ref_fn(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (f == 2'd0)      r[i] = x[i] && y[i];
      else if (f == 2'd1) r[i] = !(x[i] && y[i]);
      else if (f == 2'd2) r[i] = !(x[i] || y[i]);
      else                r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [1:0] f,
                            input logic [31:0] x, input logic [31:0] y);
    if (r) begin
      m_out = 32'h0; m_vld = 1'b0; m_ill = 1'b0; m_zero = 1'b0;
    end else if (e) begin
      m_out  = ref_fn(f, x, y);
      m_vld  = 1'b1;
      m_ill  = (f == 2'd3);
      m_zero = (m_out == 32'h0);
    end else begin
      m_vld = 1'b0; m_ill = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_out"}, out, m_out);
    chk({tag, "_vld"}, {31'h0, out_valid}, {31'h0, m_vld});
    chk({tag, "_ill"}, {31'h0, illegal_op}, {31'h0, m_ill});
`ifdef LOGIC32_ZERO_FLAG_EN
    chk({tag, "_zero"}, {31'h0, zero}, {31'h0, m_zero});
`endif
  endtask

  // Drive one cycle's inputs, clock it, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] f,
                      input logic [31:0] x, input logic [31:0] y, input string tag);
    rst = r; en = e; op = f; a = x; b = y;
    @(posedge clk);
    model_edge(r, e, f, x, y);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;

    // Reset held for two cycles with a live request
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset");
      chk("reset_out_const", out, 32'h0);
      chk("reset_vld_const", {31'h0, out_valid}, 32'h0);
    end

    step(1'b0, 1'b1, 2'b00, 32'hF0F0_A5A5, 32'hFF00_5A5A, "and");
    chk("and_out_const", out, 32'hF000_0000);
    chk("and_vld_const", {31'h0, out_valid}, 32'h1);

    step(1'b0, 1'b1, 2'b01, 32'hAAAA_AAAA, 32'h5555_5555, "nand");
    chk("nand_out_const", out, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 2'b10, 32'hAAAA_AAAA, 32'h5555_5555, "nor");
    chk("nor_out_const", out, 32'h0000_0000);
    chk("nor_vld_const", {31'h0, out_valid}, 32'h1);
`ifdef LOGIC32_ZERO_FLAG_EN
    chk("nor_zero_const", {31'h0, zero}, 32'h1);
`endif

    // Hold: inputs wander while en is low
    step(1'b0, 1'b1, 2'b01, 32'h0F0F_0000, 32'h00FF_0000, "preh");
    held = m_out;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 2'($urandom_range(3)), $urandom, $urandom, "hold");
      chk("hold_out_const", out, held);
    end

    step(1'b0, 1'b1, 2'b11, 32'h1234_5678, 32'h1234_5678, "rsvd");
    chk("rsvd_out_const", out, 32'h0);
    chk("rsvd_ill_const", {31'h0, illegal_op}, 32'h1);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, "rsvd_idle");
    chk("rsvd_idle_ill_const", {31'h0, illegal_op}, 32'h0);

    step(1'b0, 1'b1, 2'b01, 32'h0, 32'h0, "pre_rp");
    step(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rst_prio");
    chk("rst_prio_out_const", out, 32'h0);
    chk("rst_prio_vld_const", {31'h0, out_valid}, 32'h0);

    // Randomized traffic, with occasional reset and idle cycles
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(19) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
           $urandom, ($urandom_range(7) == 0) ? 32'h0 : $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
